compat_trig_sched: RTL

COMPAT_TRIG_SCHED -- requirements
Module: compat_trig_sched

---
 rtl/compat_trig_sched_if.sv | 26 ++
 rtl/compat_trig_sched.sv | 124 ++++++++++++
 2 files changed

// File: rtl/compat_trig_sched_if.sv
// compat_trig_sched_if: request/readout bundle between the trigger scheduler
// and the surrounding acquisition logic. Clock and reset stay outside the bundle.
interface compat_trig_sched_if;
  logic        SYNC;
  logic [3:0]  TRIG_IN;
  logic [3:0]  SRC_ENABLE;
  logic [11:0] HOLDOFF;
  logic        ACK;
  logic [1:0]  ENABLE40;
  logic        TRIG_OUT;
  logic [3:0]  TRIG_SRC;
  logic        BUSY;
  logic [15:0] LOST_COUNT;

  // Driver side: the acquisition controller / testbench.
  modport master (
    output SYNC, TRIG_IN, SRC_ENABLE, HOLDOFF, ACK,
    input  ENABLE40, TRIG_OUT, TRIG_SRC, BUSY, LOST_COUNT
  );

  // Scheduler side.
  modport slave (
    input  SYNC, TRIG_IN, SRC_ENABLE, HOLDOFF, ACK,
    output ENABLE40, TRIG_OUT, TRIG_SRC, BUSY, LOST_COUNT
  );
endinterface

// File: rtl/compat_trig_sched.sv
// compat_trig_sched: trigger scheduler running at 120 MHz.
// Generates the 40 MHz phase (0,1,2) for downsampled trigger modules, fires a
// one-cycle trigger on any enabled request, then holds off for HOLDOFF 40 MHz
// ticks and/or waits for the readout acknowledge before re-arming.
// Optional feature macro: COMPAT_TRIG_LOST_COUNT_EN -- when defined, LOST_COUNT
// counts (saturating) request rising edges seen while busy; otherwise it is 0.
module compat_trig_sched (
  input  logic                CLK120,
  input  logic                RESET_N,
  compat_trig_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FIRE     = 2'd1,
    HOLDOFF  = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [1:0]  phase;
  logic [11:0] hold_cnt;
  logic        ack_lat;
  logic [3:0]  trig_src;
  logic [3:0]  req;
  logic        req_any;
  logic        ack_seen;
  logic        busy;

  assign req      = bus.TRIG_IN & bus.SRC_ENABLE;
  assign req_any  = |req;
  // An ACK arriving in the current cycle counts as already latched, so an ACK
  // in the FIRE cycle or the last holdoff cycle skips WAIT_ACK.
  assign ack_seen = ack_lat | bus.ACK;
  assign busy     = (state != IDLE);

  // 40 MHz phase counter; SYNC realigns it to the ADC strobe.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N)              phase <= 2'd0;
    else if (bus.SYNC)         phase <= 2'd0;
    else if (phase == 2'd2)    phase <= 2'd0;
    else                       phase <= phase + 2'd1;
  end

  // Next-state logic of the fire / holdoff / acknowledge sequence.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_any) state_n = FIRE;
      FIRE: begin
        if (bus.HOLDOFF != 12'd0) state_n = HOLDOFF;
        else if (ack_seen)        state_n = IDLE;
        else                      state_n = WAIT_ACK;
      end
      HOLDOFF: begin
        // The tick that takes the counter from 1 to 0 is the last busy cycle.
        if ((phase == 2'd2) && (hold_cnt <= 12'd1))
          state_n = ack_seen ? IDLE : WAIT_ACK;
      end
      WAIT_ACK: if (ack_seen) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  // Holdoff counter: loaded in FIRE, counts 40 MHz ticks in HOLDOFF.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N)
      hold_cnt <= 12'd0;
    else if (state == FIRE)
      hold_cnt <= bus.HOLDOFF;
    else if ((state == HOLDOFF) && (phase == 2'd2) && (hold_cnt != 12'd0))
      hold_cnt <= hold_cnt - 12'd1;
  end

  // ACK latch: captures ACK from FIRE onward, cleared whenever IDLE is next.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N)                     ack_lat <= 1'b0;
    else if (state_n == IDLE)         ack_lat <= 1'b0;
    else if (busy && bus.ACK)         ack_lat <= 1'b1;
  end

  // Source mask captured on the IDLE->FIRE transition, held until next fire.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N)                        trig_src <= 4'd0;
    else if ((state == IDLE) && req_any) trig_src <= req;
  end

  assign bus.ENABLE40 = phase;
  assign bus.TRIG_OUT = (state == FIRE);
  assign bus.TRIG_SRC = trig_src;
  assign bus.BUSY     = busy;

`ifdef COMPAT_TRIG_LOST_COUNT_EN
  logic        req_prev;
  logic [15:0] lost_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count request rising edges that arrive while busy, saturating at 65535.
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      req_prev <= 1'b0;
      lost_cnt <= 16'd0;
    end else begin
      req_prev <= req_any;
      if (busy && req_any && !req_prev)
        lost_cnt <= sat_inc16(lost_cnt);
    end
  end

  assign bus.LOST_COUNT = lost_cnt;
`else
  assign bus.LOST_COUNT = 16'd0;
`endif

endmodule
